// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Fetch program counter with fixed-priority next-PC selection
//               (exception > stall > return > jump > branch > sequential).
//               Optional return-address stack, built when PC_RAS_EN is
//               defined; otherwise `ret` always uses ret_target.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [WIDTH-1:0]             branch_target,
  input  logic                         jump,
  input  logic [WIDTH-1:0]             jump_target,
  input  logic                         call,
  input  logic                         ret,
  input  logic [WIDTH-1:0]             ret_target,
  input  logic                         exc,
  input  logic [WIDTH-1:0]             exc_vector,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_ret_pc;

  // Wraps modulo 2^WIDTH with no overflow indication.
  assign pc_plus = r_pc + WIDTH'(STEP);
  assign pc      = r_pc;

`ifdef PC_RAS_EN
  localparam int c_PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [c_PW-1:0]  r_sp;      // next slot to write; top is r_sp-1
  logic [c_PW:0]    r_count;
  logic [c_PW-1:0]  w_top_idx;
  logic             w_push;
  logic             w_pop;
  logic             w_ras_hit;

  assign w_top_idx = r_sp - c_PW'(1);
  assign w_ras_hit = (r_count != '0);
  // Return beats call, and a stalled or excepting cycle moves nothing.
  assign w_push    = jump & call & ~ret & ~stall & ~exc;
  assign w_pop     = ret & ~stall & ~exc;
  // Top entry is read combinationally so a return costs no bubble.
  assign w_ret_pc  = w_ras_hit ? r_ras[w_top_idx] : ret_target;
  assign ras_count = r_count;

  // Stack pointer and occupancy; a full stack wraps and overwrites the oldest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (exc) begin
      r_count <= '0;
    end else if (w_push) begin
      r_sp <= r_sp + c_PW'(1);
      if (r_count != (c_PW+1)'(RAS_DEPTH)) begin
        r_count <= r_count + (c_PW+1)'(1);
      end
    end else if (w_pop && w_ras_hit) begin
      r_sp    <= w_top_idx;
      r_count <= r_count - (c_PW+1)'(1);
    end
  end

  // Entry storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_sp] <= pc_plus;
    end
  end
`else
  logic w_unused_call;

  assign w_unused_call = call;
  assign w_ret_pc      = ret_target;
  assign ras_count     = '0;
`endif

  // Fixed-priority next-PC selection; exception overrides stall.
  always_comb begin
    w_next_pc = pc_plus;
    if (exc) begin
      w_next_pc = exc_vector;
    end else if (stall) begin
      w_next_pc = r_pc;
    end else if (ret) begin
      w_next_pc = w_ret_pc;
    end else if (jump) begin
      w_next_pc = jump_target;
    end else if (branch_taken) begin
      w_next_pc = branch_target;
    end
  end

  // PC register with asynchronous reset to the boot address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit (RESET_PC=0x0040_0000).
//               RAS scenarios are exercised when PC_RAS_EN is defined; the
//               default build checks that returns fall back to ret_target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] ret_target = '0;
  logic        exc = 1'b0;
  logic [31:0] exc_vector = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [2:0]  ras_count;

  int n_chk  = 0;
  int n_pass = 0;

  pc_unit #(
    .WIDTH(32), .RESET_PC(32'h0040_0000), .STEP(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .call(call),
    .ret(ret), .ret_target(ret_target),
    .exc(exc), .exc_vector(exc_vector),
    .pc(pc), .pc_plus(pc_plus), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; exc = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic set_pc(input logic [31:0] a);
    jump = 1; jump_target = a;
    tick();
    jump = 0;
  endtask

  task automatic jal(input logic [31:0] tgt);
    jump = 1; call = 1; jump_target = tgt;
    tick();
    jump = 0; call = 0;
  endtask

  task automatic test_reset();
    tick();
    n_chk++;
    if (pc !== 32'h0040_0000) $display("FAIL reset_pc: got %h expected %h", pc, 32'h0040_0000);
    else n_pass++;
    n_chk++;
    if (pc_plus !== 32'h0040_0004) $display("FAIL reset_pc_plus: got %h expected %h", pc_plus, 32'h0040_0004);
    else n_pass++;
    n_chk++;
    if (ras_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", ras_count);
    else n_pass++;
    rst_n = 1;
    for (int i = 1; i <= 5; i++) begin
      logic [31:0] exp;
      tick();
      exp = 32'h0040_0000 + 32'(4 * i);
      n_chk++;
      if (pc !== exp) $display("FAIL seq_%0d: got %h expected %h", i, pc, exp);
      else n_pass++;
    end
    // Mid-cycle asynchronous assertion.
    #3 rst_n = 0;
    #1;
    n_chk++;
    if (pc !== 32'h0040_0000) $display("FAIL async_reset: got %h expected %h", pc, 32'h0040_0000);
    else n_pass++;
    tick();
    rst_n = 1;
  endtask

  task automatic test_priority();
    do_reset();
    set_pc(32'h100);
    n_chk++;
    if (pc !== 32'h100) $display("FAIL jump_to_100: got %h expected %h", pc, 32'h100);
    else n_pass++;
    branch_taken = 1; branch_target = 32'h200; jump = 1; jump_target = 32'h300;
    tick();
    clear_inputs();
    n_chk++;
    if (pc !== 32'h300) $display("FAIL jump_over_branch: got %h expected %h", pc, 32'h300);
    else n_pass++;
    stall = 1; branch_taken = 1; branch_target = 32'h200;
    tick();
    n_chk++;
    if (pc !== 32'h300) $display("FAIL stall_hold: got %h expected %h", pc, 32'h300);
    else n_pass++;
    stall = 0;
    tick();
    clear_inputs();
    n_chk++;
    if (pc !== 32'h200) $display("FAIL branch_after_stall: got %h expected %h", pc, 32'h200);
    else n_pass++;
  endtask

  task automatic test_exc();
    do_reset();
    set_pc(32'h100);
    jal(32'h400);
`ifdef PC_RAS_EN
    n_chk++;
    if (ras_count !== 3'd1) $display("FAIL exc_pre_count: got %0d expected 1", ras_count);
    else n_pass++;
`endif
    stall = 1; exc = 1; exc_vector = 32'h8000_0180; ret = 1; ret_target = 32'h9999;
    tick();
    clear_inputs();
    n_chk++;
    if (pc !== 32'h8000_0180) $display("FAIL exc_over_stall: got %h expected %h", pc, 32'h8000_0180);
    else n_pass++;
    n_chk++;
    if (ras_count !== 3'd0) $display("FAIL exc_count: got %0d expected 0", ras_count);
    else n_pass++;
    // Stack cleared, so a return must fall back to ret_target.
    ret = 1; ret_target = 32'hBEEF;
    tick();
    clear_inputs();
    n_chk++;
    if (pc !== 32'hBEEF) $display("FAIL ret_after_exc: got %h expected %h", pc, 32'hBEEF);
    else n_pass++;
  endtask

  task automatic test_ret_nesting();
    logic [31:0] exp_ret [4];
    do_reset();
    set_pc(32'h100);
    jal(32'h200);
    jal(32'h300);
    jal(32'h1000);
    n_chk++;
    if (pc !== 32'h1000) $display("FAIL jal_target: got %h expected %h", pc, 32'h1000);
    else n_pass++;
`ifdef PC_RAS_EN
    n_chk++;
    if (ras_count !== 3'd3) $display("FAIL jal_count: got %0d expected 3", ras_count);
    else n_pass++;
    exp_ret[0] = 32'h304; exp_ret[1] = 32'h204; exp_ret[2] = 32'h104; exp_ret[3] = 32'hDEAD;
`else
    exp_ret[0] = 32'hDEAD; exp_ret[1] = 32'hDEAD; exp_ret[2] = 32'hDEAD; exp_ret[3] = 32'hDEAD;
`endif
    ret_target = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      ret = 1;
      tick();
      ret = 0;
      n_chk++;
      if (pc !== exp_ret[i]) $display("FAIL ret_%0d: got %h expected %h", i, pc, exp_ret[i]);
      else n_pass++;
    end
    n_chk++;
    if (ras_count !== 3'd0) $display("FAIL ret_empty_count: got %0d expected 0", ras_count);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    set_pc(32'h10);
    jal(32'h20);
    jal(32'h30);
    jal(32'h40);
    jal(32'h50);
    jal(32'h2000);
`ifdef PC_RAS_EN
    n_chk++;
    if (ras_count !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", ras_count);
    else n_pass++;
    ret_target = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp;
      exp = 32'h54 - 32'(16 * i);
      ret = 1;
      tick();
      ret = 0;
      n_chk++;
      if (pc !== exp) $display("FAIL ovf_pop_%0d: got %h expected %h", i, pc, exp);
      else n_pass++;
    end
`else
    n_chk++;
    if (ras_count !== 3'd0) $display("FAIL noras_count: got %0d expected 0", ras_count);
    else n_pass++;
`endif
  endtask

  task automatic test_ret_call_mix();
    do_reset();
    set_pc(32'h100);
    jal(32'h200);
    // ret with call+jump: return wins and nothing is pushed.
    ret = 1; call = 1; jump = 1; jump_target = 32'h700; ret_target = 32'hDEAD;
    tick();
    clear_inputs();
`ifdef PC_RAS_EN
    n_chk++;
    if (pc !== 32'h104) $display("FAIL ret_call_pc: got %h expected %h", pc, 32'h104);
    else n_pass++;
`else
    n_chk++;
    if (pc !== 32'hDEAD) $display("FAIL ret_call_pc: got %h expected %h", pc, 32'hDEAD);
    else n_pass++;
`endif
    n_chk++;
    if (ras_count !== 3'd0) $display("FAIL ret_call_count: got %0d expected 0", ras_count);
    else n_pass++;
    // call without jump is ignored.
    call = 1;
    tick();
    call = 0;
    n_chk++;
    if (ras_count !== 3'd0) $display("FAIL call_only_count: got %0d expected 0", ras_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    set_pc(32'hFFFF_FFFC);
    n_chk++;
    if (pc_plus !== 32'h0) $display("FAIL wrap_pc_plus: got %h expected %h", pc_plus, 32'h0);
    else n_pass++;
    tick();
    n_chk++;
    if (pc !== 32'h0) $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_exc();
    test_ret_nesting();
    test_overflow();
    test_ret_call_mix();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS cores: holds the fetch PC, selects the next PC from sequential, branch, jump, return and exception sources with fixed priority, and supports pipeline stall. An optional return-address stack (RAS) predicts `jr $ra` targets from earlier `jal` calls. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
- `WIDTH`, 32, PC and address width in bits
- `RESET_PC`, 0, PC value loaded on reset; `WIDTH` bits
- `STEP`, 4, sequential increment in bytes
- `RAS_DEPTH`, 4, RAS entries; power of two, ≥2

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold PC and RAS this cycle
- `branch_taken`  in  1  redirect to `branch_target`
- `branch_target`  in  WIDTH  branch destination
- `jump`  in  1  redirect to `jump_target`
- `jump_target`  in  WIDTH  jump destination
- `call`  in  1  qualifies `jump` as `jal`: push return address
- `ret`  in  1  return request (`jr $ra`)
- `ret_target`  in  WIDTH  resolved `$ra` value; used when RAS empty or disabled
- `exc`  in  1  exception redirect
- `exc_vector`  in  WIDTH  exception handler address
- `pc`  out  WIDTH  current fetch PC (register)
- `pc_plus`  out  WIDTH  `pc + STEP`, combinational
- `ras_count`  out  clog2(RAS_DEPTH)+1  valid RAS entries (0 when RAS compiled out)

## Operation
- Next-PC priority, highest first: `exc` → `exc_vector`; `stall` → hold; `ret` → RAS top (or `ret_target`); `jump` → `jump_target`; `branch_taken` → `branch_target`; else `pc_plus`.
- `exc` overrides `stall`; all other requests are ignored while `stall`=1 (requester re-presents them).
- Arithmetic modulo 2^WIDTH: `pc` = 2^WIDTH−STEP advances to 0, no flag.
- RAS push: `jump`&&`call`, not stalled, no `exc`, no `ret`; pushes `pc_plus`. Full RAS: push overwrites oldest entry (circular), `ras_count` stays `RAS_DEPTH`.
- RAS pop: `ret`, not stalled, no `exc`. count>0: next PC = top entry, count−1. count=0: next PC = `ret_target`, count stays 0.
- `ret` and `call` together: `ret` wins, no push.
- `exc` (stalled or not) clears `ras_count` to 0; entry contents undefined.
- `call` without `jump`: ignored.

## Timing
- Reset (`rst_n` low, asynchronous, any time): `pc`=`RESET_PC`, `ras_count`=0, `pc_plus`=`RESET_PC+STEP`. Release is synchronous to the next rising edge; first advance on the first rising edge with `rst_n`=1.
- Redirect latency: one cycle; request sampled at edge N, `pc` shows target after edge N.
- RAS top is readable in the same cycle as `ret` (no bubble); push and pop take effect at the same edge as the PC update.
- Reset mid-stall or mid-redirect: reset wins, pending request lost.

## Configuration
- `PC_RAS_EN` defined: RAS of `RAS_DEPTH` entries built as described.
- Not defined: no RAS storage; `ret` always selects `ret_target`, `call` only affects nothing beyond `jump`, `ras_count` tied to 0.

## Test plan
- Reset with `RESET_PC`=0x0040_0000, 5 idle cycles → `pc` = 0x0040_0000, 0x0040_0004 … 0x0040_0014; assert `rst_n` mid-cycle → `pc` immediately 0x0040_0000.
- `pc`=0x100, `branch_taken`+`jump` together (targets 0x200/0x300) → `pc`=0x300; next cycle `stall`=1 with `branch_taken` → `pc` holds 0x300.
- `exc` with `stall`=1, `exc_vector`=0x8000_0180 → `pc`=0x8000_0180, `ras_count`=0.
- RAS (`PC_RAS_EN`, depth 4): `jal` at 0x100, 0x200, 0x300 then three `ret` (`ret_target`=0xDEAD) → `pc` 0x304, 0x204, 0x104; fourth `ret` → 0xDEAD, `ras_count`=0.
- RAS overflow: five `jal` at 0x10,0x20,0x30,0x40,0x50 → `ras_count`=4; four pops → 0x54,0x44,0x34,0x24.
- Wrap: `pc`=0xFFFF_FFFC, no requests → `pc`=0x0000_0000.
